instr_fetch_unit: RTL

Parametrised instruction fetch front-end for the RISC core. It replaces the single PC register, single instruction register and addr_sel fetch path with a prefetching unit: it owns the program counter, issues reads to instruction memory over a req/ack handshake that tolerates wait states, and buffers fetched words in a FIFO. The decoder consumes instructions through a valid/ready interface. The execute stage redirects fetch on branches and on PC reset.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/instr_fetch_unit_if.sv | 31 +++
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/instr_fetch_unit.sv | 118 +++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front-end: FSM state encoding and
// the default-width prefetch buffer entry layout.
package fetch_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] pc;
        logic [DEF_DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus and decoder-side instruction stream of the fetch unit.
interface instr_fetch_unit_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
);
    // Memory side: a read completes on a rising edge with mem_req=1 and mem_ack=1;
    // mem_addr is sampled by the memory when the request starts. Decoder side: the
    // head moves on an edge with ir_valid=1 and ir_ready=1; ir_valid never waits on ir_ready.
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  ir_valid;
    logic [DATA_WIDTH-1:0] ir_data;
    logic [ADDR_WIDTH-1:0] ir_pc;
    logic                  ir_ready;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata,
        output ir_valid, ir_data, ir_pc,
        input  ir_ready
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata,
        input  ir_valid, ir_data, ir_pc,
        output ir_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// First-word-fall-through FIFO on registered storage; flush empties it and wins
// over any push or pop on the same edge.
module fetch_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign dout  = mem_q[rd_q];

    // A pop frees the slot a same-edge push needs, so a full FIFO still accepts.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = din;
                wr_d        = wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_d = rd_q + 1'b1;
            end
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Prefetching instruction fetch unit: owns the PC, keeps one memory read in
// flight and buffers returned words for the decoder.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fetch_en,
    input  logic                          redirect,
    input  logic [ADDR_WIDTH-1:0]         redirect_pc,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy,
    output fetch_state_t                  state_dbg,
    instr_fetch_unit_if.master            bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  req_q, req_d;

    entry_t                push_entry, head_entry;
    logic                  push, pop, fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count, occ_next;
    logic                  space;

    assign push_entry = '{pc: pc_q, instr: bus.mem_rdata};
    assign push       = (state_q == REQ) && bus.mem_ack && !redirect;
    assign pop        = !fifo_empty && bus.ir_ready;
    assign occ_next   = fifo_count + CW'(push) - CW'(pop);
    assign space      = (occ_next < CW'(FIFO_DEPTH));

    fetch_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (push_entry),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end else if (fetch_en && !fifo_full) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                    if (bus.mem_ack) begin
                        state_d = fetch_en ? REQ : IDLE;
                    end else begin
                        state_d = DISCARD;
                    end
                end else if (bus.mem_ack) begin
                    pc_d    = pc_q + 1'b1;
                    state_d = (fetch_en && space) ? REQ : IDLE;
                end
            end
            DISCARD: begin
                // The stale read is still owed by memory; keep requesting until it lands.
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (bus.mem_ack) begin
                    state_d = fetch_en ? REQ : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
        end
    end

    assign bus.mem_req  = req_q;
    assign bus.mem_addr = pc_q;
    assign bus.ir_valid = !fifo_empty;
    assign bus.ir_data  = head_entry.instr;
    assign bus.ir_pc    = head_entry.pc;
    assign occupancy    = fifo_count;
    assign state_dbg    = state_q;

endmodule
